// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the CONV host-side memory responder.
package conv_pkg;

  localparam logic [2:0] CSEL_IDLE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int IMG_PIX  = 4096;
  localparam int L1_WORDS = 1024;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/conv_bank_ram.sv
// Single-port-write, asynchronous-read storage bank; contents are never reset.
module conv_bank_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read of the address being written this cycle sees the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_host_mem.sv
// Host-side responder for CONV: loads the image, serves image/layer memories
// during the run, then streams the layer-1 result out.
module conv_host_mem
  import conv_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int DW    = 20,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          done,
  output logic          csel_err,
  output state_t        dbg_state
);

  localparam int L1AW = $clog2(L1_WORDS);
  localparam int PIX  = IMG_W * IMG_W;
  localparam logic [AW-1:0]   LAST_PIX = AW'(PIX - 1);
  localparam logic [L1AW-1:0] LAST_L1  = L1AW'(L1_WORDS - 1);

  // Handshake rule for both streams: a beat transfers on a rising edge where
  // valid and ready are both high; the producer holds data stable otherwise.

  state_t          state_q, state_d;
  logic [AW-1:0]   ld_cnt;
  logic [L1AW-1:0] dr_ptr;
  logic            busy_q;
  logic            live;
  logic            out_valid_q;
  logic            csel_err_q;

  logic load_beat, drain_hs, in_run, reload;
  logic l0_we, l1_we, bad_wr;
  logic [DW-1:0]   img_rd, l0_rd, l1_rd;
  logic [L1AW-1:0] l1_raddr;

  // live keeps load_ready low until the first edge after reset release.
  assign load_ready = (state_q == S_LOAD) && live;
  assign ready      = (state_q == S_START);
  assign done       = (state_q == S_DONE);
  assign out_valid  = out_valid_q;
  assign csel_err   = csel_err_q;
  assign dbg_state  = state_q;

  assign load_beat = load_valid && load_ready;
  assign drain_hs  = (state_q == S_DRAIN) && out_valid_q && out_ready;
  assign in_run    = (state_q == S_RUN);
  assign reload    = (state_q == S_DONE) && load_valid;
  assign l0_we     = cwr && in_run && (csel == CSEL_L0);
  assign l1_we     = cwr && in_run && (csel == CSEL_L1);
  assign bad_wr    = cwr && !(l0_we || l1_we);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (load_beat && (ld_cnt == LAST_PIX)) state_d = S_START;
      S_START: if (busy) state_d = S_RUN;
      S_RUN:   if (busy_q && !busy) state_d = S_DRAIN;
      S_DRAIN: if (drain_hs && (dr_ptr == LAST_L1)) state_d = S_DONE;
      S_DONE:  if (load_valid) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      ld_cnt      <= '0;
      dr_ptr      <= '0;
      busy_q      <= 1'b0;
      live        <= 1'b0;
      out_valid_q <= 1'b0;
      csel_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy;
      live    <= 1'b1;

      if (reload)         ld_cnt <= '0;
      else if (load_beat) ld_cnt <= ld_cnt + 1'b1;

      if (reload)        dr_ptr <= '0;
      else if (drain_hs) dr_ptr <= dr_ptr + 1'b1;

      if (reload)      csel_err_q <= 1'b0;
      else if (bad_wr) csel_err_q <= 1'b1;

      // Valid rises one cycle into DRAIN and falls right after the last word.
      if (state_q == S_DRAIN) out_valid_q <= !(drain_hs && (dr_ptr == LAST_L1));
      else                    out_valid_q <= 1'b0;
    end
  end

  assign l1_raddr = (state_q == S_DRAIN) ? dr_ptr : caddr_rd[L1AW-1:0];

  conv_bank_ram #(.DEPTH(PIX), .DW(DW), .AW(AW)) u_img (
    .clk(clk), .we(load_beat), .waddr(ld_cnt), .wdata(load_data),
    .raddr(iaddr), .rdata(img_rd)
  );

  conv_bank_ram #(.DEPTH(PIX), .DW(DW), .AW(AW)) u_l0 (
    .clk(clk), .we(l0_we), .waddr(caddr_wr), .wdata(cdata_wr),
    .raddr(caddr_rd), .rdata(l0_rd)
  );

  conv_bank_ram #(.DEPTH(L1_WORDS), .DW(DW), .AW(L1AW)) u_l1 (
    .clk(clk), .we(l1_we), .waddr(caddr_wr[L1AW-1:0]), .wdata(cdata_wr),
    .raddr(l1_raddr), .rdata(l1_rd)
  );

  assign idata    = img_rd;
  assign out_data = (state_q == S_DRAIN) ? l1_rd : '0;

  always_comb begin
    cdata_rd = '0;
    if (crd) begin
      case (csel)
        CSEL_L0: cdata_rd = l0_rd;
        CSEL_L1: cdata_rd = l1_rd;
        default: cdata_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_host_mem.sv
// Directed bench for conv_host_mem: load, run-time memory access, drain, reload, reset abort.
module tb_conv_host_mem;
  import conv_pkg::*;

  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, ready;
  logic          busy = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic [DW-1:0] idata;
  logic          cwr = 1'b0;
  logic [AW-1:0] caddr_wr = '0;
  logic [DW-1:0] cdata_wr = '0;
  logic          crd = 1'b0;
  logic [AW-1:0] caddr_rd = '0;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel = CSEL_IDLE;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          done, csel_err;
  state_t        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] l1_model [L1_WORDS];

  conv_host_mem #(.IMG_W(64), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .csel_err(csel_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver: full-rate image load, pixel i carries base+i
  task automatic load_image(input int base);
    for (int i = 0; i < IMG_PIX; i++) begin
      load_valid = 1'b1;
      load_data  = DW'(base + i);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", ready); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_load_ready got %b want 0", load_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (csel_err !== 1'b0) begin n_err++; $display("FAIL rst_csel_err got %b want 0", csel_err); end
    n_cmp++; if (dbg_state !== S_LOAD) begin n_err++; $display("FAIL rst_state got %0d want %0d", dbg_state, S_LOAD); end
    reset = 1'b1;
    #1;
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL release_load_ready got %b want 0", load_ready); end
    tick();
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL post_release_load_ready got %b want 1", load_ready); end
  endtask

  task automatic test_load;
    for (int i = 0; i < IMG_PIX; i++) begin
      if (i == 100) begin
        load_valid = 1'b0;
        load_data  = 20'hFFFFF;
        repeat (5) tick();
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL stall_load_ready got %b want 1", load_ready); end
      end
      if (i == IMG_PIX - 1) begin
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ready_early got %b want 0", ready); end
      end
      load_valid = 1'b1;
      load_data  = DW'(i);
      tick();
    end
    load_valid = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL load_ready_rise got %b want 1", ready); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL load_ready_after got %b want 0", load_ready); end
    iaddr = 12'h0A5; #1;
    n_cmp++; if (idata !== 20'h000A5) begin n_err++; $display("FAIL img_0a5 got %h want 000a5", idata); end
    iaddr = 12'd99; #1;
    n_cmp++; if (idata !== 20'd99) begin n_err++; $display("FAIL img_99 got %h want %h", idata, 20'd99); end
    iaddr = 12'd100; #1;
    n_cmp++; if (idata !== 20'd100) begin n_err++; $display("FAIL img_100 got %h want %h", idata, 20'd100); end
    iaddr = 12'd101; #1;
    n_cmp++; if (idata !== 20'd101) begin n_err++; $display("FAIL img_101 got %h want %h", idata, 20'd101); end
    iaddr = 12'hFFF; #1;
    n_cmp++; if (idata !== 20'h00FFF) begin n_err++; $display("FAIL img_fff got %h want 00fff", idata); end
  endtask

  task automatic test_run;
    busy = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL start_hold got %b want 1", ready); end
    busy = 1'b1;
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL run_ready got %b want 0", ready); end
    n_cmp++; if (dbg_state !== S_RUN) begin n_err++; $display("FAIL run_state got %0d want %0d", dbg_state, S_RUN); end
    // L0 write then same-address overwrite with concurrent read (old data)
    csel = CSEL_L0; cwr = 1'b1; caddr_wr = 12'h123; cdata_wr = 20'h11111;
    tick();
    cdata_wr = 20'h5A5A5; crd = 1'b1; caddr_rd = 12'h123; #1;
    n_cmp++; if (cdata_rd !== 20'h11111) begin n_err++; $display("FAIL rw_same_old got %h want 11111", cdata_rd); end
    tick();
    cwr = 1'b0; #1;
    n_cmp++; if (cdata_rd !== 20'h5A5A5) begin n_err++; $display("FAIL l0_123 got %h want 5a5a5", cdata_rd); end
    crd = 1'b0; #1;
    n_cmp++; if (cdata_rd !== 20'h0) begin n_err++; $display("FAIL crd0 got %h want 00000", cdata_rd); end
    // fill all of L1
    csel = CSEL_L1;
    for (int i = 0; i < L1_WORDS; i++) begin
      cwr = 1'b1; caddr_wr = AW'(i); cdata_wr = l1_model[i];
      tick();
    end
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h3FF; #1;
    n_cmp++; if (cdata_rd !== 20'h00123) begin n_err++; $display("FAIL l1_3ff got %h want 00123", cdata_rd); end
    caddr_rd = 12'hC05; #1;
    n_cmp++; if (cdata_rd !== l1_model[5]) begin n_err++; $display("FAIL l1_alias got %h want %h", cdata_rd, l1_model[5]); end
    // illegal bank select
    csel = 3'b010; cwr = 1'b1; caddr_wr = 12'h123; cdata_wr = 20'hFFFFF; caddr_rd = 12'h123; #1;
    n_cmp++; if (cdata_rd !== 20'h0) begin n_err++; $display("FAIL bad_csel_rd got %h want 00000", cdata_rd); end
    tick();
    cwr = 1'b0; #1;
    n_cmp++; if (csel_err !== 1'b1) begin n_err++; $display("FAIL csel_err_set got %b want 1", csel_err); end
    csel = CSEL_L0; #1;
    n_cmp++; if (cdata_rd !== 20'h5A5A5) begin n_err++; $display("FAIL l0_untouched got %h want 5a5a5", cdata_rd); end
    csel = CSEL_L1; #1;
    n_cmp++; if (cdata_rd !== l1_model[12'h123]) begin n_err++; $display("FAIL l1_untouched got %h want %h", cdata_rd, l1_model[12'h123]); end
    crd = 1'b0; csel = CSEL_IDLE;
    iaddr = 12'h7C0; #1;
    n_cmp++; if (idata !== 20'h007C0) begin n_err++; $display("FAIL img_run got %h want 007c0", idata); end
  endtask

  task automatic test_drain;
    logic [DW-1:0] held_data;
    logic          held;
    logic [DW-1:0] want;
    int            hs;
    int            cyc;
    logic          pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < L1_WORDS; i++) exp_q.push_back(l1_model[i]);
    busy = 1'b0;
    tick();
    n_cmp++; if (dbg_state !== S_DRAIN) begin n_err++; $display("FAIL drain_entry got %0d want %0d", dbg_state, S_DRAIN); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid_early got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid_rise got %b want 1", out_valid); end
    hs = 0; cyc = 0; held = 1'b0; held_data = '0;
    while (hs < L1_WORDS && cyc < 6000) begin
      out_ready = pat[cyc % 4];
      #1;
      if (held) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== held_data) begin
          n_err++; $display("FAIL stall_hold got %b/%h want 1/%h", out_valid, out_data, held_data);
        end
      end
      if (out_valid && out_ready) begin
        want = exp_q.pop_front();
        n_cmp++; if (out_data !== want) begin n_err++; $display("FAIL drain_word[%0d] got %h want %h", hs, out_data, want); end
        hs++;
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        held_data = out_data;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    n_cmp++; if (hs != L1_WORDS) begin n_err++; $display("FAIL drain_timeout got %0d want %0d", hs, L1_WORDS); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid_fall got %b want 0", out_valid); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_set got %b want 1", done); end
    n_cmp++; if (csel_err !== 1'b1) begin n_err++; $display("FAIL csel_err_sticky got %b want 1", csel_err); end
  endtask

  task automatic test_reload_reset;
    load_valid = 1'b1; load_data = 20'hEEEEE; #1;
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL done_load_ready got %b want 0", load_ready); end
    tick();
    load_valid = 1'b0;
    n_cmp++; if (dbg_state !== S_LOAD) begin n_err++; $display("FAIL reload_state got %0d want %0d", dbg_state, S_LOAD); end
    n_cmp++; if (csel_err !== 1'b0) begin n_err++; $display("FAIL csel_err_clear got %b want 0", csel_err); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reload_done got %b want 0", done); end
    load_image(1);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reload_ready got %b want 1", ready); end
    iaddr = 12'h000; #1;
    n_cmp++; if (idata !== 20'h00001) begin n_err++; $display("FAIL reload_img0 got %h want 00001", idata); end
    iaddr = 12'hFFF; #1;
    n_cmp++; if (idata !== 20'h01000) begin n_err++; $display("FAIL reload_imgfff got %h want 01000", idata); end
    busy = 1'b1; tick();
    busy = 1'b0; tick();
    tick();
    out_ready = 1'b1;
    repeat (500) tick();
    n_cmp++; if (out_data !== l1_model[500]) begin n_err++; $display("FAIL drain2_word500 got %h want %h", out_data, l1_model[500]); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", done); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL abort_load_ready got %b want 0", load_ready); end
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL abort_release got %b want 1", load_ready); end
    iaddr = 12'h0A5; #1;
    n_cmp++; if (idata !== 20'h000A6) begin n_err++; $display("FAIL mem_kept got %h want 000a6", idata); end
  endtask

  initial begin
    for (int i = 0; i < L1_WORDS; i++)
      l1_model[i] = (i == L1_WORDS - 1) ? 20'h00123 : (DW'(i * 257) ^ 20'hA5A5A);
    test_reset();
    test_load();
    test_run();
    test_drain();
    test_reload_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
